// File: rtl/feedforward_section_if.sv
// Bus between the feedforward (FIR numerator) stage and its neighbours:
// the sample stream in, the coefficient write port, and the filtered result out.
interface feedforward_section_if #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16
);
  logic [DATA_W-1:0] in;
  logic              in_valid;
  logic              coef_we;
  logic [2:0]        coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              sat;

  // Source side: produces samples and coefficient writes, consumes the result
  modport master (
    output in, in_valid, coef_we, coef_addr, coef_data,
    input  out, out_valid, sat
  );

  // Filter side
  modport slave (
    input  in, in_valid, coef_we, coef_addr, coef_data,
    output out, out_valid, sat
  );
endinterface

// File: rtl/feedforward_section.sv
// Feedforward (FIR numerator) stage of the IIR filter:
//   y[n] = sum_k b_k * x[n-k], rescaled by 2^-FRAC_BITS (floor), saturated to DATA_W.
// Two register stages: products, then sum/scale/saturate. The output holds
// between valid strobes because the downstream stage samples it every cycle.
module feedforward_section #(
  parameter int DATA_W    = 32,
  parameter int COEF_W    = 16,
  parameter int FRAC_BITS = 14,
  parameter int NTAPS     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  feedforward_section_if.slave  bus
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(NTAPS);
  // Tap 0 of the post-shift line is the incoming sample itself, so only the
  // older NTAPS-1 samples need storage; the oldest register would never be read.
  localparam int HIST_N = NTAPS - 1;

  localparam logic signed [COEF_W-1:0] COEF_ONE = {{(COEF_W-1){1'b0}}, 1'b1} << FRAC_BITS;

  // Clip a scaled accumulator to DATA_W; returns {clipped_flag, value}
  function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-DATA_W:0] top;
    top = v[ACC_W-1:DATA_W-1];
    if ((&top) || (~|top)) begin
      saturate = {1'b0, v[DATA_W-1:0]};
    end else if (v[ACC_W-1]) begin
      saturate = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      saturate = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  logic signed [DATA_W-1:0] hist_q [HIST_N];
  logic signed [DATA_W-1:0] hist_d [HIST_N];
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic signed [COEF_W-1:0] coef_d [NTAPS];
  logic signed [PROD_W-1:0] p_q    [NTAPS];
  logic signed [PROD_W-1:0] p_d    [NTAPS];
  logic signed [DATA_W-1:0] tap_s  [NTAPS];

  logic                     v1_q, v1_d;
  logic [DATA_W-1:0]        out_q, out_d;
  logic                     sat_q, sat_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [ACC_W-1:0]  acc_s;
  logic signed [ACC_W-1:0]  scaled_s;
  logic [DATA_W:0]          clip_s;

  // Post-shift tap view and delay-line advance on accepted samples
  always_comb begin
    tap_s[0] = bus.in;
    for (int k = 1; k < NTAPS; k++) begin
      tap_s[k] = hist_q[k-1];
    end
    for (int k = 0; k < HIST_N; k++) begin
      if (bus.in_valid) begin
        hist_d[k] = tap_s[k];
      end else begin
        hist_d[k] = hist_q[k];
      end
    end
  end

  // Stage 1: one product per tap using the coefficients in force before this edge
  always_comb begin
    v1_d = bus.in_valid;
    for (int k = 0; k < NTAPS; k++) begin
      if (bus.in_valid) begin
        p_d[k] = PROD_W'(coef_q[k]) * PROD_W'(tap_s[k]);
      end else begin
        p_d[k] = p_q[k];
      end
    end
  end

  // Coefficient bank write; addresses beyond the last tap match nothing
  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      if (bus.coef_we && (bus.coef_addr == 3'(k))) begin
        coef_d[k] = bus.coef_data;
      end else begin
        coef_d[k] = coef_q[k];
      end
    end
  end

  // Stage 2: wide sum, floor rescale, clip; result held when no sample arrives
  always_comb begin
    acc_s = '0;
    for (int k = 0; k < NTAPS; k++) begin
      acc_s = acc_s + ACC_W'(p_q[k]);
    end
    scaled_s    = acc_s >>> FRAC_BITS;
    clip_s      = saturate(scaled_s);
    out_valid_d = v1_q;
    if (v1_q) begin
      out_d = clip_s[DATA_W-1:0];
      sat_d = clip_s[DATA_W];
    end else begin
      out_d = out_q;
      sat_d = sat_q;
    end
  end

  // State registers with synchronous reset to pass-through defaults
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < HIST_N; k++) begin
        hist_q[k] <= '0;
      end
      for (int k = 0; k < NTAPS; k++) begin
        p_q[k]    <= '0;
        coef_q[k] <= (k == 0) ? COEF_ONE : '0;
      end
      v1_q        <= 1'b0;
      out_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < HIST_N; k++) begin
        hist_q[k] <= hist_d[k];
      end
      for (int k = 0; k < NTAPS; k++) begin
        p_q[k]    <= p_d[k];
        coef_q[k] <= coef_d[k];
      end
      v1_q        <= v1_d;
      out_q       <= out_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.sat       = sat_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_feedforward_section.sv
// Bench for feedforward_section: directed scenarios with literal expectations
// plus a randomized stream, all checked every cycle against a behavioural model
// (coefficient array, sample history, queue of scheduled results).
module tb_feedforward_section;

  logic clk = 1'b0;
  logic rst_n;

  feedforward_section_if #(.DATA_W(32), .COEF_W(16)) bus ();

  feedforward_section #(
    .DATA_W(32), .COEF_W(16), .FRAC_BITS(14), .NTAPS(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     cyc;
    longint val;
    bit     s;
  } exp_t;

  exp_t   pend[$];
  longint b[5];
  longint h[5];          // h[0] newest accepted sample, h[4] oldest
  longint held_out;
  bit     held_sat;
  bit     exp_valid;
  int     cyc;
  int     n_checks;
  int     n_fail;

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      b[k] = 0;
      h[k] = 0;
    end
    b[0] = 16384;
    pend.delete();
    held_out = 0;
    held_sat = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare after it
  task automatic step(input bit r, input bit v, input logic [31:0] x,
                      input bit we = 1'b0, input logic [2:0] a = 3'd0,
                      input logic [15:0] d = 16'd0);
    longint acc;
    exp_t   e;
    rst_n         = r;
    bus.in_valid  = v;
    bus.in        = x;
    bus.coef_we   = we;
    bus.coef_addr = a;
    bus.coef_data = d;
    cyc++;
    exp_valid = 1'b0;
    if (!r) begin
      model_reset();
    end else begin
      if (pend.size() > 0 && pend[0].cyc == cyc) begin
        exp_valid = 1'b1;
        e = pend.pop_front();
        held_out = e.val;
        held_sat = e.s;
      end
      if (v) begin
        for (int k = 4; k > 0; k--) h[k] = h[k-1];
        h[0] = longint'($signed(x));
        acc = 0;
        for (int k = 0; k < 5; k++) acc += b[k] * h[k];
        acc = acc >>> 14;
        e.cyc = cyc + 1;
        if (acc > 64'sd2147483647) begin
          e.val = 64'sd2147483647;
          e.s   = 1'b1;
        end else if (acc < -64'sd2147483648) begin
          e.val = -64'sd2147483648;
          e.s   = 1'b1;
        end else begin
          e.val = acc;
          e.s   = 1'b0;
        end
        pend.push_back(e);
      end
      if (we && a < 3'd5) b[int'(a)] = longint'($signed(d));
    end
    @(posedge clk);
    #1;
    chk("model_out_valid", longint'(bus.out_valid), longint'(exp_valid));
    chk("model_out", longint'($signed(bus.out)), held_out);
    chk("model_sat", longint'(bus.sat), longint'(held_sat));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 32'd0);
  endtask

  task automatic sample(input logic [31:0] x);
    step(1'b1, 1'b1, x);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    step(1'b1, 1'b0, 32'd0, 1'b1, a, d);
  endtask

  task automatic reset_dut();
    step(1'b0, 1'b0, 32'd0);
  endtask

  task automatic lit(input string name, input bit v, input longint o, input bit s);
    chk({name, "_valid"}, longint'(bus.out_valid), longint'(v));
    chk({name, "_out"}, longint'($signed(bus.out)), o);
    chk({name, "_sat"}, longint'(bus.sat), longint'(s));
  endtask

  task automatic load_impulse_coefs();
    wr(3'd0, 16'd16384);
    wr(3'd1, 16'd8192);
    wr(3'd2, 16'd4096);
    wr(3'd3, 16'd2048);
    wr(3'd4, 16'd1024);
  endtask

  initial begin
    logic [31:0] x;
    int          t;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    model_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in = '0; bus.coef_we = 1'b0;
    bus.coef_addr = '0; bus.coef_data = '0;

    // Reset state
    reset_dut();
    reset_dut();
    lit("reset", 1'b0, 0, 1'b0);

    // Pass-through with default coefficients
    sample(32'd1000);
    sample(32'd0);
    lit("pass_1000", 1'b1, 1000, 1'b0);
    idle();
    lit("pass_0", 1'b1, 0, 1'b0);

    // Impulse response
    reset_dut();
    load_impulse_coefs();
    sample(32'd100);
    sample(32'd0); lit("imp_0", 1'b1, 100, 1'b0);
    sample(32'd0); lit("imp_1", 1'b1, 50, 1'b0);
    sample(32'd0); lit("imp_2", 1'b1, 25, 1'b0);
    sample(32'd0); lit("imp_3", 1'b1, 12, 1'b0);
    sample(32'd0); lit("imp_4", 1'b1, 6, 1'b0);
    idle();        lit("imp_5", 1'b1, 0, 1'b0);
    idle();        lit("imp_hold", 1'b0, 0, 1'b0);

    // Saturation both ways, then an in-range result
    reset_dut();
    wr(3'd0, 16'd32767);
    wr(3'd6, 16'd1234);            // out-of-range address: no effect
    sample(32'h7FFF_FFFF);
    sample(32'h8000_0000); lit("sat_pos", 1'b1, 64'sd2147483647, 1'b1);
    sample(32'd4);         lit("sat_neg", 1'b1, -64'sd2147483648, 1'b1);
    idle();                lit("sat_none", 1'b1, 7, 1'b0);

    // Coefficient write colliding with a sample, and gaps
    reset_dut();
    step(1'b1, 1'b1, 32'd400, 1'b1, 3'd0, 16'd8192);
    idle(); lit("coll_old", 1'b1, 400, 1'b0);
    idle(); lit("gap_hold", 1'b0, 400, 1'b0);
    sample(32'd400);
    idle(); lit("coll_new", 1'b1, 200, 1'b0);

    // Reset with samples in flight
    reset_dut();
    load_impulse_coefs();
    sample(32'd100);
    step(1'b0, 1'b1, 32'd50); lit("mid_rst", 1'b0, 0, 1'b0);
    idle();                   lit("mid_rst_drop", 1'b0, 0, 1'b0);
    sample(32'd300);
    idle();                   lit("mid_rst_default", 1'b1, 300, 1'b0);

    // Floor rounding of a negative result
    reset_dut();
    wr(3'd0, 16'd8192);
    sample(-32'sd3);
    idle(); lit("neg_floor", 1'b1, -2, 1'b0);

    // Randomized stream with coefficient writes and occasional resets
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: x = $urandom;
        1: begin t = int'($urandom_range(0, 2000)) - 1000; x = t; end
        2: x = ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        default: x = $urandom;
      endcase
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 70), x,
           ($urandom_range(0, 9) < 2), 3'($urandom_range(0, 7)), 16'($urandom));
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
